// File: rtl/data_island_scheduler.sv
// data_island_scheduler
//   Places one HDMI data island inside each horizontal blanking interval.
//   On blank_start it works out how many 32-pixel packets fit after the fixed
//   lead/preamble/guard/tail overhead, grants min(request, fit, MAX_PACKETS)
//   and then walks the island: LEAD control -> 8 preamble -> 2 leading guard
//   -> 32*N data -> 2 trailing guard -> back to control.
//
// Ports
//   clk_pixel            in   pixel clock
//   reset                in   asynchronous active-high reset
//   blank_start          in   one-cycle pulse on the first blanking pixel
//   blank_len            in   blanking length, sampled with blank_start
//   packets_req          in   packets wanted this line (0..31)
//   video_field_end      in   end-of-field pulse (statistics only)
//   period               out  0 control, 1 preamble, 2 guard band, 3 data
//   packet_enable        out  pulse one cycle before each packet's first pixel
//   packet_pixel_counter out  pixel index inside the current packet, 0 elsewhere
//   packets_granted      out  packet count of the current or last island
//   busy                 out  island in progress
//   island_pkt_total     out  (ISLAND_STATS_EN only) packets completed since
//                             the last video_field_end, saturating
//
// Optional feature macro: ISLAND_STATS_EN
module data_island_scheduler #(
  parameter int LEAD_CTRL    = 4,
  parameter int TAIL_RESERVE = 22,
  parameter int MAX_PACKETS  = 18,
  parameter int BLANK_W      = 12
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               blank_start,
  input  logic [BLANK_W-1:0] blank_len,
  input  logic [4:0]         packets_req,
  input  logic               video_field_end,
  output logic [1:0]         period,
  output logic               packet_enable,
  output logic [4:0]         packet_pixel_counter,
  output logic [4:0]         packets_granted,
`ifdef ISLAND_STATS_EN
  output logic [15:0]        island_pkt_total,
`endif
  output logic               busy
);

  localparam int OVH   = LEAD_CTRL + 8 + 2 + 2 + TAIL_RESERVE;
  localparam int CNT_W = 8;
  localparam logic [BLANK_W:0] OVH_W   = (BLANK_W+1)'(OVH);
  localparam logic [BLANK_W:0] MIN_LEN = (BLANK_W+1)'(OVH + 32);
  localparam logic [BLANK_W:0] CAP_W   = (BLANK_W+1)'(MAX_PACKETS);

  typedef enum logic [2:0] {
    IDLE, LEAD, PREAMBLE, GUARD_L, DATA, GUARD_T
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       pix_reg, pix_next;
  logic [4:0]       remain_reg, remain_next;
  logic [4:0]       granted_reg, granted_next;
  logic [1:0]       period_reg, period_next;
  logic             pe_reg, pe_next;
  logic             busy_reg, busy_next;

  // Packet fit, one bit wider than blank_len so short blanking never wraps.
  logic [BLANK_W:0] len_ext, excess, fit, req_ext, min_a, min_b;
  logic [4:0]       grant;

  always_comb begin
    len_ext = {1'b0, blank_len};
    excess  = len_ext - OVH_W;
    fit     = (len_ext >= MIN_LEN) ? (excess >> 5) : '0;
    req_ext = (BLANK_W+1)'(packets_req);
    min_a   = (req_ext < fit) ? req_ext : fit;
    min_b   = (min_a < CAP_W) ? min_a : CAP_W;
    grant   = min_b[4:0];
  end

  // Next-state logic. Outputs are decoded from the next state and registered,
  // so each output changes in the same cycle as the state it belongs to.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pix_next     = 5'd0;
    remain_next  = remain_reg;
    granted_next = granted_reg;
    case (state_reg)
      IDLE: begin
        if (blank_start) begin
          granted_next = grant;
          remain_next  = grant;
          if (grant != 5'd0) begin
            // Blank_start cycle is control pixel 0, so LEAD covers the rest.
            state_next = LEAD;
            cnt_next   = CNT_W'(LEAD_CTRL - 2);
          end
        end
      end
      LEAD: begin
        if (cnt_reg == '0) begin
          state_next = PREAMBLE;
          cnt_next   = CNT_W'(7);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PREAMBLE: begin
        if (cnt_reg == '0) begin
          state_next = GUARD_L;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      GUARD_L: begin
        if (cnt_reg == '0) begin
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DATA: begin
        pix_next = pix_reg + 5'd1;
        if (pix_reg == 5'd31) begin
          remain_next = remain_reg - 5'd1;
          if (remain_reg == 5'd1) begin
            state_next = GUARD_T;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      GUARD_T: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      PREAMBLE:        period_next = 2'd1;
      GUARD_L, GUARD_T: period_next = 2'd2;
      DATA:            period_next = 2'd3;
      default:         period_next = 2'd0;
    endcase
    busy_next = (state_next != IDLE);
    // Second guard pixel, or the last pixel of a packet that has a successor.
    pe_next = ((state_next == GUARD_L) && (cnt_next == '0)) ||
              ((state_next == DATA) && (pix_next == 5'd31) && (remain_next > 5'd1));
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pix_reg     <= 5'd0;
      remain_reg  <= 5'd0;
      granted_reg <= 5'd0;
      period_reg  <= 2'd0;
      pe_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pix_reg     <= pix_next;
      remain_reg  <= remain_next;
      granted_reg <= granted_next;
      period_reg  <= period_next;
      pe_reg      <= pe_next;
      busy_reg    <= busy_next;
    end
  end

  assign period               = period_reg;
  assign packet_enable        = pe_reg;
  assign packet_pixel_counter = pix_reg;
  assign packets_granted      = granted_reg;
  assign busy                 = busy_reg;

`ifdef ISLAND_STATS_EN
  logic [15:0] total_reg;
  logic        pkt_done;

  assign pkt_done = (state_reg == DATA) && (pix_reg == 5'd31);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      total_reg <= 16'd0;
    end else if (video_field_end) begin
      // A packet finishing on the clearing edge starts the new field's count.
      total_reg <= pkt_done ? 16'd1 : 16'd0;
    end else if (pkt_done && (total_reg != 16'hFFFF)) begin
      total_reg <= total_reg + 16'd1;
    end
  end

  assign island_pkt_total = total_reg;
`else
  logic unused_field_end;
  assign unused_field_end = video_field_end;
`endif

endmodule
